muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op and FSM state encodings for muldiv_unit
// Purpose: op select codes, FSM state encoding and a divide-class helper.
// Ports: none (package).
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULLO = 2'b00,
    OP_MULHI = 2'b01,
    OP_DIVQ  = 2'b10,
    OP_DIVR  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic is_div(op_t o);
    return (o == OP_DIVQ) || (o == OP_DIVR);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned multiply/divide unit with register-file writeback
// Purpose: one-bit-per-cycle shift-add multiply and restoring divide.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op       request and operation select (MULLO/MULHI/DIVQ/DIVR)
//   a, b, dest      operands and destination register address
//   busy, done      iterating flag, one-cycle completion pulse
//   divByZero       qualifies done for a divide with b==0
//   write, writeAddr, writeValue  registered register-file write port
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int width    = 32,
  parameter int regCount = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  op,
  input  logic [width-1:0]            a,
  input  logic [width-1:0]            b,
  input  logic [$clog2(regCount)-1:0] dest,
  output logic                        busy,
  output logic                        done,
  output logic                        divByZero,
  output logic                        write,
  output logic [$clog2(regCount)-1:0] writeAddr,
  output logic [width-1:0]            writeValue
);

  localparam int CW = $clog2(width + 1);
  localparam int AW = $clog2(regCount);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  state_t           state;
  op_t              op_q;
  logic [AW-1:0]    dest_q;
  logic [CW-1:0]    cnt;
  // hi: product upper half / partial remainder
  // lo: multiplier being shifted out / dividend shifting into quotient
  // opnd: multiplicand or divisor
  logic [width-1:0] hi;
  logic [width-1:0] lo;
  logic [width-1:0] opnd;

  logic [width-1:0] hi_nx;
  logic [width-1:0] lo_nx;
  logic [width-1:0] result;
  logic [width:0]   sum;
  logic [width:0]   shifted;
  logic [width:0]   diff;

  op_t op_in;
  assign op_in = op_t'(op);

  assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
  assign shifted = {hi, lo[width-1]};
  assign diff    = shifted - {1'b0, opnd};

  always_comb begin
    hi_nx = hi;
    lo_nx = lo;
    if (is_div(op_q)) begin
      // Restoring step: keep the trial subtraction only when it did not borrow.
      if (!diff[width]) begin
        hi_nx = diff[width-1:0];
        lo_nx = {lo[width-2:0], 1'b1};
      end else begin
        hi_nx = shifted[width-1:0];
        lo_nx = {lo[width-2:0], 1'b0};
      end
    end else begin
      // Shift-add step: carry of the add becomes the new product MSB.
      hi_nx = sum[width:1];
      lo_nx = {sum[0], lo[width-1:1]};
    end
  end

  always_comb begin
    result = lo_nx;
    case (op_q)
      OP_MULLO: result = lo_nx;
      OP_MULHI: result = hi_nx;
      OP_DIVQ:  result = lo_nx;
      OP_DIVR:  result = hi_nx;
      default:  result = lo_nx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      write      <= 1'b0;
      divByZero  <= 1'b0;
      writeAddr  <= '0;
      writeValue <= '0;
      op_q       <= OP_MULLO;
      dest_q     <= '0;
      hi         <= '0;
      lo         <= '0;
      opnd       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done      <= 1'b0;
          write     <= 1'b0;
          divByZero <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
          if (start) begin
            op_q   <= op_in;
            dest_q <= dest;
            cnt    <= '0;
            hi     <= '0;
            opnd   <= is_div(op_in) ? b : a;
            lo     <= is_div(op_in) ? a : b;
            if (is_div(op_in) && (b == '0)) begin
              // Divide by zero finishes immediately with fixed results.
              state      <= ST_DONE;
              done       <= 1'b1;
              write      <= 1'b1;
              divByZero  <= 1'b1;
              writeAddr  <= dest;
              writeValue <= (op_in == OP_DIVQ) ? '1 : a;
            end else begin
              state <= ST_BUSY;
              busy  <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            write      <= 1'b1;
            writeAddr  <= dest_q;
            writeValue <= result;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  dest;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic        write;
  logic [4:0]  writeAddr;
  logic [31:0] writeValue;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.width(32), .regCount(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .dest       (dest),
    .busy       (busy),
    .done       (done),
    .divByZero  (divByZero),
    .write      (write),
    .writeAddr  (writeAddr),
    .writeValue (writeValue)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after an edge; leaves the bench #1 into cycle 1 after start was sampled.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] d);
    start = 1'b1; op = o; a = x; b = y; dest = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_write(output int cyc);
    cyc = 1;
    while (!write && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] d, input int exp_cyc,
                        input logic [31:0] exp_val, input logic exp_dbz);
    int cyc;
    start_op(o, x, y, d);
    wait_write(cyc);
    check({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_value"}, 64'(writeValue), 64'(exp_val));
    check({tag, "_addr"}, 64'(writeAddr), 64'(d));
    check({tag, "_dbz"}, 64'(divByZero), 64'(exp_dbz));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_write_drop"}, 64'({write, done, divByZero}), 64'd0);
    check({tag, "_value_hold"}, 64'(writeValue), 64'(exp_val));
  endtask

  initial begin
    int cyc;
    int nw;
    int wc;
    logic [31:0] wv;

    rst = 1'b1; start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; dest = 5'd1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 64'({busy, done, write, divByZero}), 64'd0);
    check("reset_addr", 64'(writeAddr), 64'd0);
    check("reset_value", 64'(writeValue), 64'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    // MULLO 7*6, check busy in the first iterating cycle as well
    start_op(2'b00, 32'd7, 32'd6, 5'd5);
    check("mullo_busy_c1", 64'(busy), 64'd1);
    wait_write(cyc);
    check("mullo_cycle", 64'(cyc), 64'd33);
    check("mullo_value", 64'(writeValue), 64'd42);
    check("mullo_addr", 64'(writeAddr), 64'd5);
    check("mullo_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    run_op("mulhi_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 33, 32'hFFFF_FFFE, 1'b0);
    run_op("mullo_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 33, 32'h0000_0001, 1'b0);
    run_op("divq_100_7", 2'b10, 32'd100, 32'd7, 5'd11, 33, 32'd14, 1'b0);
    run_op("divr_100_7", 2'b11, 32'd100, 32'd7, 5'd12, 33, 32'd2, 1'b0);
    run_op("divq_zero", 2'b10, 32'h1234, 32'd0, 5'd13, 1, 32'hFFFF_FFFF, 1'b1);
    run_op("divr_zero", 2'b11, 32'h1234, 32'd0, 5'd14, 1, 32'h0000_1234, 1'b1);
    run_op("divq_big", 2'b10, 32'hFFFF_FFFF, 32'h0001_0000, 5'd31, 33, 32'h0000_FFFF, 1'b0);
    run_op("divr_big", 2'b11, 32'hFFFF_FFFF, 32'h0001_0000, 5'd30, 33, 32'h0000_FFFF, 1'b0);
    run_op("mulhi_mid", 2'b01, 32'h8000_0000, 32'd6, 5'd2, 33, 32'd3, 1'b0);

    // A second start while busy must be ignored
    start_op(2'b00, 32'd3, 32'd4, 5'd3);
    nw = 0; wc = 0; wv = '0;
    for (int i = 1; i <= 45; i++) begin
      if (write) begin
        nw++; wv = writeValue; wc = i;
      end
      if (i == 10) begin
        start = 1'b1; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("restart_count", 64'(nw), 64'd1);
    check("restart_value", 64'(wv), 64'd12);
    check("restart_cycle", 64'(wc), 64'd33);

    // Reset during iteration aborts the operation
    start_op(2'b00, 32'd7, 32'd6, 5'd4);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    nw = 0;
    for (int i = 0; i < 45; i++) begin
      if (write) nw++;
      @(posedge clk); #1;
    end
    check("abort_writes", 64'(nw), 64'd0);
    check("abort_value", 64'(writeValue), 64'd0);

    // Back-to-back: start accepted in the DONE cycle
    start_op(2'b10, 32'd100, 32'd7, 5'd6);
    wait_write(cyc);
    check("b2b_first_value", 64'(writeValue), 64'd14);
    start_op(2'b00, 32'd3, 32'd4, 5'd7);
    check("b2b_busy_no_gap", 64'({busy, write}), 64'b10);
    wait_write(cyc);
    check("b2b_cycle", 64'(cyc), 64'd33);
    check("b2b_value", 64'(writeValue), 64'd12);
    check("b2b_addr", 64'(writeAddr), 64'd7);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
